// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide HI/LO unit.
package mdu_pkg;

  localparam int W       = 32;
  localparam int PW      = 64;
  localparam int MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_MUL_FIX,
    ST_DIV_GO,
    ST_DIV_WAIT
  } mdu_state_e;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself (2^31 unsigned).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_mul_seq.sv
// Unsigned 32x32 shift-add multiplier, one iteration per cycle, multiplier LSB first.
module mdu_mul_seq
  import mdu_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  input  logic          load,
  input  logic [W-1:0]  mcand,
  input  logic [W-1:0]  mplier,
  output logic [PW-1:0] product,
  output logic          done
);

  logic [W-1:0] mcand_q;
  logic [4:0]   count;
  logic         busy;
  logic [W:0]   sum;

  // Upper half accumulates partial sums while the multiplier shifts out of the lower half.
  assign sum  = {1'b0, product[PW-1:W]} + (product[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  assign done = busy && (count == 5'(MD_ITER - 1));

  always_ff @(posedge clock) begin
    if (resetn) begin
      product <= '0;
      mcand_q <= '0;
      count   <= '0;
      busy    <= 1'b0;
    end else if (load) begin
      product <= {{W{1'b0}}, mplier};
      mcand_q <= mcand;
      count   <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      product <= {sum, product[W-1:1]};
      count   <= count + 5'd1;
      if (count == 5'(MD_ITER - 1))
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide control and HI/LO registers; drives the external divider handshake.
module mdu_hilo
  import mdu_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         stall,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_start,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_busy
);

  mdu_state_e    state;
  md_op_e        op_e;
  logic          neg;
  logic          mul_load;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [PW-1:0] mul_prod;
  logic [PW-1:0] fixed_prod;
  logic          mul_done;

  assign op_e       = md_op_e'(op);
  assign mul_load   = (state == ST_IDLE) && op_valid && (op_e == MD_MULT || op_e == MD_MULTU);
  assign mul_a      = (op_e == MD_MULT) ? mag(rs_val) : rs_val;
  assign mul_b      = (op_e == MD_MULT) ? mag(rt_val) : rt_val;
  assign fixed_prod = neg ? -mul_prod : mul_prod;
  assign stall      = (state != ST_IDLE);

  mdu_mul_seq u_mul (
    .clock   (clock),
    .resetn  (resetn),
    .load    (mul_load),
    .mcand   (mul_a),
    .mplier  (mul_b),
    .product (mul_prod),
    .done    (mul_done)
  );

  always_ff @(posedge clock) begin
    if (resetn) begin
      state     <= ST_IDLE;
      hi        <= '0;
      lo        <= '0;
      div_a     <= '0;
      div_b     <= '0;
      div_start <= 1'b0;
      neg       <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_e)
              MD_MTHI:  hi <= rs_val;
              MD_MTLO:  lo <= rs_val;
              MD_MULT: begin
                neg   <= rs_val[W-1] ^ rt_val[W-1];
                state <= ST_MUL;
              end
              MD_MULTU: begin
                neg   <= 1'b0;
                state <= ST_MUL;
              end
              // Divide-by-zero is accepted but leaves HI/LO untouched.
              MD_DIV: begin
                if (rt_val != '0) begin
                  div_a     <= rs_val;
                  div_b     <= rt_val;
                  div_start <= 1'b1;
                  state     <= ST_DIV_GO;
                end
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (mul_done)
            state <= ST_MUL_FIX;
        end
        ST_MUL_FIX: begin
          {hi, lo} <= fixed_prod;
          state    <= ST_IDLE;
        end
        // div_busy is not yet valid here; the divider raises it one cycle after start.
        ST_DIV_GO: state <= ST_DIV_WAIT;
        ST_DIV_WAIT: begin
          if (!div_busy) begin
            lo    <= div_q;
            hi    <= div_r;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo with a behavioural 32-cycle signed divider beside it.
module tb_mdu_hilo;

  logic        clock = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_start;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_busy = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mdu_hilo dut (
    .clock     (clock),
    .resetn    (resetn),
    .op_valid  (op_valid),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi        (hi),
    .lo        (lo),
    .stall     (stall),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_start (div_start),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_busy  (div_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    return (sb == 0) ? 32'd0 : 32'(sa / sb);
  endfunction

  function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    return (sb == 0) ? 32'd0 : 32'(sa % sb);
  endfunction

  // External divider: busy rises the cycle after start and stays up for 32 cycles.
  int div_cnt = 0;
  always @(posedge clock) begin
    if (resetn) begin
      div_busy <= 1'b0;
      div_cnt  <= 0;
      div_q    <= '0;
      div_r    <= '0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      div_cnt  <= 32;
      div_q    <= sdiv(div_a, div_b);
      div_r    <= srem(div_a, div_b);
    end else if (div_busy) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1)
        div_busy <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op, plus how long the pipeline should stall.
  task automatic modelOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int exp_stall, output int exp_starts);
    logic [63:0] p;
    longint      sp;
    exp_stall  = 0;
    exp_starts = 0;
    case (o)
      3'd1: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        p  = 64'(sp);
        {model_hi, model_lo} = p;
        exp_stall = 33;
      end
      3'd2: begin
        p = {32'd0, a} * {32'd0, b};
        {model_hi, model_lo} = p;
        exp_stall = 33;
      end
      3'd3: begin
        if (b != 32'd0) begin
          model_lo   = sdiv(a, b);
          model_hi   = srem(a, b);
          exp_stall  = 34;
          exp_starts = 1;
        end
      end
      3'd4: model_hi = a;
      3'd5: model_lo = a;
      default: ;
    endcase
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (stall && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (stall)
      checkOutput("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one op; optionally present a junk MTHI on every stalled cycle, which must be ignored.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input bit junk);
    int cycles;
    int starts;
    int exp_stall;
    int exp_starts;
    bit done;
    waitIdle();
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    @(negedge clock);
    op_valid = 1'b0;
    if (junk) begin
      op_valid = 1'b1;
      op       = 3'd4;
      rs_val   = 32'hDEAD_BEEF;
    end
    if (o == 3'd3 && b != 32'd0) begin
      checkOutput({tag, "_div_a"}, 64'(div_a), 64'(a));
      checkOutput({tag, "_div_b"}, 64'(div_b), 64'(b));
    end
    cycles = 0;
    starts = 0;
    done   = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (div_start)
        starts++;
      if (!stall) begin
        done = 1'b1;
      end else begin
        cycles++;
        @(negedge clock);
      end
    end
    op_valid = 1'b0;
    if (!done)
      checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
    modelOp(o, a, b, exp_stall, exp_starts);
    checkOutput({tag, "_stall"}, 64'(cycles), 64'(exp_stall));
    checkOutput({tag, "_starts"}, 64'(starts), 64'(exp_starts));
    checkOutput({tag, "_hi"}, 64'(hi), 64'(model_hi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(model_lo));
  endtask

  task automatic resetMidMul();
    waitIdle();
    op_valid = 1'b1;
    op       = 3'd1;
    rs_val   = 32'h1234_5678;
    rt_val   = 32'h9ABC_DEF0;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (9) @(negedge clock);
    checkOutput("mid_mul_stall", 64'(stall), 64'd1);
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
    model_hi = '0;
    model_lo = '0;
    checkOutput("rst_mid_stall", 64'(stall), 64'd0);
    checkOutput("rst_mid_hi", 64'(hi), 64'd0);
    checkOutput("rst_mid_lo", 64'(lo), 64'd0);
    checkOutput("rst_mid_start", 64'(div_start), 64'd0);
    checkOutput("rst_mid_div_a", 64'(div_a), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    resetn   = 1'b1;
    op_valid = 1'b0;
    op       = 3'd0;
    rs_val   = '0;
    rt_val   = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_stall", 64'(stall), 64'd0);
    checkOutput("rst_start", 64'(div_start), 64'd0);
    checkOutput("rst_div_a", 64'(div_a), 64'd0);
    checkOutput("rst_div_b", 64'(div_b), 64'd0);
    resetn = 1'b0;
    @(negedge clock);

    applyStimulus("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    checkOutput("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus("mult_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus("mult_min1", 3'd1, 32'h8000_0000, 32'd1, 1'b0);
    applyStimulus("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    applyStimulus("mthi", 3'd4, 32'h0000_1234, 32'd0, 1'b0);
    applyStimulus("mtlo", 3'd5, 32'h0000_5678, 32'd0, 1'b0);
    applyStimulus("div_zero", 3'd3, 32'd100, 32'd0, 1'b0);
    checkOutput("div_zero_const", {hi, lo}, 64'h0000_1234_0000_5678);

    applyStimulus("mult_junk", 3'd1, 32'd5, 32'd3, 1'b1);
    applyStimulus("mthi_a5", 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
    applyStimulus("mtlo_1", 3'd5, 32'h0000_0001, 32'd0, 1'b0);
    checkOutput("mt_pair_const", {hi, lo}, 64'hA5A5_A5A5_0000_0001);

    resetMidMul();
    applyStimulus("mult_6x7", 3'd1, 32'd6, 32'd7, 1'b0);
    checkOutput("mult_6x7_const", {hi, lo}, 64'd42);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (ro == 3'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)
        rb = 32'd1;
      applyStimulus($sformatf("rnd%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)) & (ro == 3'd1 || ro == 3'd2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
